// File: rtl/dsp_pkg.sv
// rtl/dsp_pkg.sv - shared select codes, OPMODE bit positions and widths for the DSP slice
package dsp_pkg;

   // Default datapath widths of the slice
   localparam int WIDTH_P_DEFAULT = 48;
   localparam int WIDTH_M_DEFAULT = 36;

   // X multiplexer select codes, OPMODE[1:0]
   localparam logic [1:0] X_ZERO = 2'd0;
   localparam logic [1:0] X_M    = 2'd1;
   localparam logic [1:0] X_P    = 2'd2;
   localparam logic [1:0] X_DAB  = 2'd3;

   // Z multiplexer select codes, OPMODE[3:2]
   localparam logic [1:0] Z_ZERO = 2'd0;
   localparam logic [1:0] Z_PCIN = 2'd1;
   localparam logic [1:0] Z_P    = 2'd2;
   localparam logic [1:0] Z_C    = 2'd3;

   // OPMODE bit positions owned by the post-adder
   localparam int OPM_X_LSB = 0;
   localparam int OPM_Z_LSB = 2;
   localparam int OPM_CIN   = 5;
   localparam int OPM_SUB   = 7;

endpackage

// File: rtl/opt_pipe_reg.sv
// rtl/opt_pipe_reg.sv - optional pipeline register with clock enable, async clear and bypass
module opt_pipe_reg #(
   parameter int WIDTH = 1,
   parameter int EN    = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ce,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   generate
      if (EN != 0) begin : g_reg
         logic [WIDTH-1:0] q_r;

         // Load on enabled rising edges; the asynchronous clear overrides the enable.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               q_r <= '0;
            end else if (ce) begin
               q_r <= d;
            end
         end

         assign q = q_r;
      end else begin : g_bypass
         // Bypassed stage: clock, reset and enable have no effect.
         logic unused_ctrl;
         assign unused_ctrl = ^{clk, rst_n, ce};
         assign q = d;
      end
   endgenerate

endmodule

// File: rtl/post_adder_accumulator.sv
// rtl/post_adder_accumulator.sv - X/Z operand select, add/subtract with carry, registered P
module post_adder_accumulator
   import dsp_pkg::*;
#(
   parameter int    WIDTH_P    = WIDTH_P_DEFAULT,
   parameter int    WIDTH_M    = WIDTH_M_DEFAULT,
   parameter int    OPMODEREG  = 1,
   parameter int    CARRYINREG = 1,
   parameter int    PREG       = 1,
   parameter string CARRYINSEL = "OPMODE5"
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [WIDTH_M-1:0] M,
   input  logic [WIDTH_P-1:0] DAB,
   input  logic [WIDTH_P-1:0] C,
   input  logic [WIDTH_P-1:0] PCIN,
   input  logic [7:0]         OPMODE,
   input  logic               CARRYIN,
   input  logic               CEOPMODE,
   input  logic               CECARRYIN,
   input  logic               CEP,
   output logic [WIDTH_P-1:0] P,
   output logic [WIDTH_P-1:0] PCOUT,
   output logic               CARRYOUT
);

   localparam bit CIN_FROM_PORT = (CARRYINSEL == "CARRYIN");

   logic [7:0]         opm;
   logic               cin_src;
   logic               cin;
   logic [WIDTH_P-1:0] p_fb;
   logic [WIDTH_P-1:0] p_q;
   logic               co_q;
   logic [WIDTH_P-1:0] x_mux;
   logic [WIDTH_P-1:0] z_mux;
   logic [WIDTH_P:0]   x_ext;
   logic [WIDTH_P:0]   z_ext;
   logic [WIDTH_P:0]   cin_ext;
   logic [WIDTH_P:0]   sum;
   logic [1:0]         x_sel;
   logic [1:0]         z_sel;

   // Bits 4 and 6 steer the pre-adder and are not used in this stage.
   logic unused_opm;
   assign unused_opm = ^{opm[6], opm[4]};

   // Control path: OPMODE and the chosen carry source, each optionally pipelined.
   opt_pipe_reg #(.WIDTH(8), .EN(OPMODEREG)) u_opmode_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .ce    (CEOPMODE),
      .d     (OPMODE),
      .q     (opm)
   );

   assign cin_src = CIN_FROM_PORT ? CARRYIN : OPMODE[OPM_CIN];

   opt_pipe_reg #(.WIDTH(1), .EN(CARRYINREG)) u_carryin_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .ce    (CECARRYIN),
      .d     (cin_src),
      .q     (cin)
   );

   // Feedback is tied off without a P register so the bypassed path cannot loop.
   generate
      if (PREG != 0) begin : g_fb
         assign p_fb = p_q;
      end else begin : g_no_fb
         assign p_fb = '0;
      end
   endgenerate

   assign x_sel = opm[OPM_X_LSB +: 2];
   assign z_sel = opm[OPM_Z_LSB +: 2];

   // X operand: zero, zero-extended product, accumulator feedback or D:A:B.
   always_comb begin
      x_mux = '0;
      case (x_sel)
         X_ZERO:  x_mux = '0;
         X_M:     x_mux = {{(WIDTH_P-WIDTH_M){1'b0}}, M};
         X_P:     x_mux = p_fb;
         X_DAB:   x_mux = DAB;
         default: x_mux = '0;
      endcase
   end

   // Z operand: zero, cascade input, accumulator feedback or C.
   always_comb begin
      z_mux = '0;
      case (z_sel)
         Z_ZERO:  z_mux = '0;
         Z_PCIN:  z_mux = PCIN;
         Z_P:     z_mux = p_fb;
         Z_C:     z_mux = C;
         default: z_mux = '0;
      endcase
   end

   assign x_ext   = {1'b0, x_mux};
   assign z_ext   = {1'b0, z_mux};
   assign cin_ext = {{WIDTH_P{1'b0}}, cin};

   // One extra bit holds the carry on add and the borrow on subtract.
   always_comb begin
      sum = '0;
      if (opm[OPM_SUB]) begin
         sum = z_ext - (x_ext + cin_ext);
      end else begin
         sum = z_ext + x_ext + cin_ext;
      end
   end

   // Result stage: P and CARRYOUT share the same enable and bypass choice.
   opt_pipe_reg #(.WIDTH(WIDTH_P), .EN(PREG)) u_p_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .ce    (CEP),
      .d     (sum[WIDTH_P-1:0]),
      .q     (p_q)
   );

   opt_pipe_reg #(.WIDTH(1), .EN(PREG)) u_carryout_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .ce    (CEP),
      .d     (sum[WIDTH_P]),
      .q     (co_q)
   );

   assign P        = p_q;
   assign PCOUT    = p_q;
   assign CARRYOUT = co_q;

endmodule

// File: tb/tb_post_adder_accumulator.sv
// tb/tb_post_adder_accumulator.sv - randomized and directed checks of the post-adder against a reference model
module tb_post_adder_accumulator;

   localparam longint unsigned MASK48 = 64'h0000_FFFF_FFFF_FFFF;
   localparam longint unsigned MASK49 = 64'h0001_FFFF_FFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [35:0] M = '0;
   logic [47:0] DAB = '0;
   logic [47:0] C = '0;
   logic [47:0] PCIN = '0;
   logic [7:0]  OPMODE = '0;
   logic        CARRYIN = 1'b0;
   logic        CEOPMODE = 1'b1;
   logic        CECARRYIN = 1'b1;
   logic        CEP = 1'b1;

   logic [47:0] p_a, pcout_a, p_b, pcout_b;
   logic        co_a, co_b;

   int n_checks = 0;
   int n_errors = 0;

   // Model state of the fully registered instance
   logic [7:0]  m_opm = '0;
   logic        m_cin = 1'b0;
   logic [47:0] m_p = '0;
   logic        m_co = 1'b0;

   always #5 clk = ~clk;

   post_adder_accumulator dut_reg (
      .clk       (clk),
      .rst_n     (rst_n),
      .M         (M),
      .DAB       (DAB),
      .C         (C),
      .PCIN      (PCIN),
      .OPMODE    (OPMODE),
      .CARRYIN   (CARRYIN),
      .CEOPMODE  (CEOPMODE),
      .CECARRYIN (CECARRYIN),
      .CEP       (CEP),
      .P         (p_a),
      .PCOUT     (pcout_a),
      .CARRYOUT  (co_a)
   );

   post_adder_accumulator #(
      .OPMODEREG  (0),
      .CARRYINREG (0),
      .PREG       (0),
      .CARRYINSEL ("CARRYIN")
   ) dut_byp (
      .clk       (clk),
      .rst_n     (rst_n),
      .M         (M),
      .DAB       (DAB),
      .C         (C),
      .PCIN      (PCIN),
      .OPMODE    (OPMODE),
      .CARRYIN   (CARRYIN),
      .CEOPMODE  (CEOPMODE),
      .CECARRYIN (CECARRYIN),
      .CEP       (CEP),
      .P         (p_b),
      .PCOUT     (pcout_b),
      .CARRYOUT  (co_b)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Post-adder arithmetic as plain integers; returns {carry, p} in 49 bits.
   function automatic longint unsigned calc(input logic [7:0] op, input logic ci,
                                            input logic [35:0] m, input logic [47:0] dab,
                                            input logic [47:0] c, input logic [47:0] pcin,
                                            input logic [47:0] pfb);
      longint unsigned x, z, s;
      case (op[1:0])
         2'd0: x = 0;
         2'd1: x = longint'(m);
         2'd2: x = longint'(pfb);
         default: x = longint'(dab);
      endcase
      case (op[3:2])
         2'd0: z = 0;
         2'd1: z = longint'(pcin);
         2'd2: z = longint'(pfb);
         default: z = longint'(c);
      endcase
      if (op[7]) s = z - (x + longint'(ci));
      else       s = z + x + longint'(ci);
      return s & MASK49;
   endfunction

   task automatic check_all(input string tag);
      longint unsigned rb;
      check({tag, ".p"},     {16'h0, p_a},     {16'h0, m_p});
      check({tag, ".pcout"}, {16'h0, pcout_a}, {16'h0, m_p});
      check({tag, ".co"},    {63'h0, co_a},    {63'h0, m_co});
      rb = calc(OPMODE, CARRYIN, M, DAB, C, PCIN, 48'h0);
      check({tag, ".byp_p"},     {16'h0, p_b},     rb & MASK48);
      check({tag, ".byp_pcout"}, {16'h0, pcout_b}, rb & MASK48);
      check({tag, ".byp_co"},    {63'h0, co_b},    {63'h0, rb[48]});
   endtask

   // Advance one rising edge, update the model from pre-edge values, then check.
   task automatic tick(input string tag);
      longint unsigned r;
      logic [7:0]  n_opm;
      logic        n_cin;
      r     = calc(m_opm, m_cin, M, DAB, C, PCIN, m_p);
      n_opm = CEOPMODE ? OPMODE : m_opm;
      n_cin = CECARRYIN ? OPMODE[5] : m_cin;
      @(posedge clk);
      if (rst_n) begin
         if (CEP) begin
            m_p  = r[47:0];
            m_co = r[48];
         end
         m_opm = n_opm;
         m_cin = n_cin;
      end
      #1;
      check_all(tag);
   endtask

   // Mid-cycle asynchronous reset with enables high, then release before the next edge.
   task automatic async_reset(input string tag);
      CEOPMODE = 1'b1; CECARRYIN = 1'b1; CEP = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      m_opm = '0; m_cin = 1'b0; m_p = '0; m_co = 1'b0;
      check({tag, ".rst_p"},  {16'h0, p_a}, 64'h0);
      check({tag, ".rst_co"}, {63'h0, co_a}, 64'h0);
      rst_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      #3;
      check("reset_p",  {16'h0, p_a},  64'h0);
      check("reset_co", {63'h0, co_a}, 64'h0);
      rst_n = 1'b1;

      // Load nonzero state, then a mid-cycle reset clears it without a clock
      OPMODE = 8'h0F; C = 48'd100; DAB = 48'd23;
      tick("pre"); tick("pre");
      async_reset("rst1");

      // Z=C, X=M: result lands one edge after the OPMODE register loads
      OPMODE = 8'h0D; C = 48'd5; M = 36'd3;
      tick("c_m0"); tick("c_m1");
      check("c_plus_m", {16'h0, p_a}, 64'd8);

      // Multiply-accumulate, then freeze with CEP low
      async_reset("rst2");
      OPMODE = 8'h09; M = 36'd10; CEP = 1'b0;
      tick("mac_load");
      CEP = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         tick("mac");
         check("mac_const", {16'h0, p_a}, 64'd10 * i);
      end
      CEP = 1'b0;
      tick("mac_hold");
      check("mac_hold_const", {16'h0, p_a}, 64'd40);
      CEP = 1'b1;

      // Subtract with borrow, then without
      OPMODE = 8'h8F; C = 48'd2; DAB = 48'd5;
      tick("sub0"); tick("sub1");
      check("sub_borrow_p",  {16'h0, p_a},  64'h0000_FFFF_FFFF_FFFD);
      check("sub_borrow_co", {63'h0, co_a}, 64'h1);
      C = 48'd7;
      tick("sub2");
      check("sub_nb_p",  {16'h0, p_a},  64'd2);
      check("sub_nb_co", {63'h0, co_a}, 64'h0);

      // Wrap-around with carry-in taken from OPMODE[5]
      OPMODE = 8'h23; DAB = 48'hFFFF_FFFF_FFFF;
      tick("wrap0"); tick("wrap1");
      check("wrap_p",  {16'h0, p_a},  64'h0);
      check("wrap_co", {63'h0, co_a}, 64'h1);

      // Control pipeline: add->sub switch takes effect one edge later
      OPMODE = 8'h0F; C = 48'd10; DAB = 48'd3;
      tick("pipe0"); tick("pipe1");
      check("pipe_add", {16'h0, p_a}, 64'd13);
      OPMODE = 8'h8F;
      tick("pipe2");
      check("pipe_old", {16'h0, p_a}, 64'd13);
      tick("pipe3");
      check("pipe_sub", {16'h0, p_a}, 64'd7);

      // Fully bypassed instance reacts in the same cycle
      CARRYIN = 1'b0; OPMODE = 8'h07; PCIN = 48'h123; DAB = 48'd1;
      #1;
      check("byp_pcin", {16'h0, p_b}, 64'h124);
      OPMODE = 8'h0A;
      #1;
      check("byp_fb_zero", {16'h0, p_b}, 64'h0);

      // Randomized traffic with occasional asynchronous resets
      for (int i = 0; i < 400; i++) begin
         OPMODE    = 8'($urandom);
         M         = {4'($urandom), 32'($urandom)};
         DAB       = {16'($urandom), 32'($urandom)};
         C         = {16'($urandom), 32'($urandom)};
         PCIN      = {16'($urandom), 32'($urandom)};
         CARRYIN   = 1'($urandom);
         if ($urandom_range(0, 7) == 0) DAB = 48'hFFFF_FFFF_FFFF;
         if ($urandom_range(0, 39) == 0) async_reset("rnd_rst");
         CEOPMODE  = ($urandom_range(0, 3) != 0);
         CECARRYIN = ($urandom_range(0, 3) != 0);
         CEP       = ($urandom_range(0, 3) != 0);
         tick("rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/post_adder_accumulator.md
Name: post_adder_accumulator

Overview:
- Post-adder / accumulator stage of the DSP slice; sits directly downstream of the M (multiplier) and D:A:B pipeline registers.
- Selects X and Z operands from product, concatenated D:A:B, C, cascade input or its own P feedback, then adds or subtracts with carry-in.
- Result is registered into P with carry-out. Optional OPMODE and carry-in pipeline registers make multiply-accumulate possible.

Parameters:
- WIDTH_P, 48, post-adder, P, C, DAB and PCIN width.
- WIDTH_M, 36, product width; zero-extended to WIDTH_P.
- OPMODEREG, 1, 1 = OPMODE registered (CEOPMODE), 0 = combinational.
- CARRYINREG, 1, 1 = selected carry-in registered (CECARRYIN), 0 = combinational.
- PREG, 1, 1 = P and CARRYOUT registered (CEP), 0 = combinational.
- CARRYINSEL, "OPMODE5", carry source: "OPMODE5" = OPMODE[5], "CARRYIN" = CARRYIN port.

Ports:
- clk  in  1  single clock, all registers on rising edge.
- rst_n  in  1  asynchronous, active-low reset of every register in the block.
- M  in  WIDTH_M  product from the upstream M stage.
- DAB  in  WIDTH_P  {D[11:0], A[17:0], B[17:0]} concatenation.
- C  in  WIDTH_P  C operand.
- PCIN  in  WIDTH_P  cascade input from the previous slice.
- OPMODE  in  8  [1:0] X select, [3:2] Z select, [5] carry-in, [7] subtract. [4] and [6] are ignored here (they belong to the pre-adder).
- CARRYIN  in  1  external carry-in.
- CEOPMODE, CECARRYIN, CEP  in  1 each  clock enables.
- P  out  WIDTH_P  result.
- PCOUT  out  WIDTH_P  identical copy of P for cascade.
- CARRYOUT  out  1  carry/borrow out of the post-adder.

Behaviour:
- Reset: rst_n=0 immediately clears the OPMODE reg, carry-in reg, P and CARRYOUT to 0, with no clock needed. Release is synchronous to the next edge. Reset overrides CE.
- Register rule: each optional reg loads on posedge when its CE=1 and holds otherwise. When its parameter is 0, the reg is bypassed combinationally and its CE is ignored.
- Operand selection uses opm, the registered or bypassed OPMODE.
- X select, opm[1:0]:
  - 0 → 0
  - 1 → {zero-ext M}
  - 2 → P_fb
  - 3 → DAB
- Z select, opm[3:2]:
  - 0 → 0
  - 1 → PCIN
  - 2 → P_fb
  - 3 → C
- P_fb is the P register output. When PREG=0, P_fb is constant 0 (no combinational loop).
- cin is the registered or bypassed value of the source chosen by CARRYINSEL.
- Arithmetic is done 49 bits wide, zero-extended:
  - opm[7]=0: s = Z + X + cin.
  - opm[7]=1: s = Z − (X + cin).
  - P_next = s[47:0], wrapping modulo 2^48. CARRYOUT_next = s[48]; when subtracting, 1 means borrow.
- Latency from M/DAB/C/PCIN to P:
  - PREG=1: 1 cycle.
  - PREG=0: 0 cycles.
- OPMODE and CARRYIN each add 1 cycle when their reg is enabled. Operands are not delayed, so upstream must align them.
- Accumulate (X=P_fb or Z=P_fb, PREG=1): P updates every CEP=1 cycle using the pre-edge P. CEP=0 freezes the accumulator.
- Simultaneous CE on all regs: the OPMODE/carry regs capture new values while P captures from the old opm and cin, i.e. a one-cycle control pipeline.
- Reset during accumulation: P returns to 0 and accumulation restarts from 0 on the first CEP edge after release.
- PCOUT == P at all times.

Decomposition:
- Shared package dsp_pkg holds:
  - localparams for X select codes (X_ZERO, X_M, X_P, X_DAB) and Z select codes (Z_ZERO, Z_PCIN, Z_P, Z_C);
  - OPMODE bit indices (OPM_SUB=7, OPM_CIN=5);
  - WIDTH_P and WIDTH_M defaults.
- One sub-module, opt_pipe_reg: parameterised WIDTH and EN, async active-low reset, CE, bypass when EN=0.
  - Instantiated four times: OPMODE, carry-in, P, CARRYOUT.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with CEs high → P=0, CARRYOUT=0 before the next edge. Release, then OPMODE=0x0D, C=5, M=3 → P=8 one edge after the OPMODE reg loads.
- MAC: OPMODE=0x09 (X=M, Z=P), M=10 for 4 CEP cycles → P = 10, 20, 30, 40. CEP=0 on cycle 5 → P holds 40.
- Subtract/borrow: OPMODE=0x8F (X=DAB, Z=C, sub), C=2, DAB=5, cin=0 → P=0xFFFF_FFFF_FFFD, CARRYOUT=1. With C=7 → P=2, CARRYOUT=0.
- Wrap/carry: X=DAB=0xFFFF_FFFF_FFFF, Z=0, OPMODE[5]=1, CARRYINSEL="OPMODE5" → P=0, CARRYOUT=1.
- Bypass: PREG=0, OPMODEREG=0, CARRYINREG=0, OPMODE=0x07 (Z=PCIN), PCIN=0x123, DAB=1 → P=0x124 in the same cycle. With OPMODE=0x0A (X=P_fb, Z=P_fb) → P=0.
- Control pipeline: change OPMODE from add to sub on the same edge CEP=1 → the sub result appears one edge later, not on the current edge.
